// File: rtl/dcache_if.sv
// CPU data port and external memory port of the direct-mapped data cache.
// The slave modport is the cache's view; master is the view of the core and memory.
interface dcache_if;
    logic        i_ce;
    logic [31:0] i_addr;
    logic [31:0] i_data_wr;
    logic [3:0]  i_wr;
    logic        i_rd;
    logic [31:0] o_data_rd;
    logic        o_valid;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data_wr;
    logic [3:0]  o_mem_wr;
    logic        o_mem_rd;
    logic [31:0] i_mem_data_rd;
    logic        i_mem_ack;

    modport slave (
        input  i_ce, i_addr, i_data_wr, i_wr, i_rd, i_mem_data_rd, i_mem_ack,
        output o_data_rd, o_valid, o_mem_addr, o_mem_data_wr, o_mem_wr, o_mem_rd
    );

    modport master (
        output i_ce, i_addr, i_data_wr, i_wr, i_rd, i_mem_data_rd, i_mem_ack,
        input  o_data_rd, o_valid, o_mem_addr, o_mem_data_wr, o_mem_wr, o_mem_rd
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Misses, writes and uncached accesses stall the core through one memory strobe/ack handshake.
module dcache #(
    parameter int INDEX_BITS   = 8,
    parameter int UNCACHED_BIT = 31
) (
    input  logic    i_clk,
    input  logic    i_rst,
    dcache_if.slave bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];
    logic [31:0]           buffer;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_data_wr;
    logic [3:0]            mem_wr;
    logic                  mem_rd;

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] m_idx;
    logic [TAG_W-1:0]      tag;
    logic [TAG_W-1:0]      m_tag;
    logic                  wr_req;
    logic                  rd_req;
    logic                  uncached;
    logic                  hit;
    logic                  m_hit;
    logic                  ack_now;
    logic [31:0]           merged;
    logic                  unused_addr_bits;

    assign idx      = bus.i_addr[INDEX_BITS+1:2];
    assign tag      = bus.i_addr[31:INDEX_BITS+2];
    assign wr_req   = |bus.i_wr;
    assign rd_req   = bus.i_rd && !wr_req;
    assign uncached = bus.i_addr[UNCACHED_BIT];
    assign hit      = valid[idx] && (tag_mem[idx] == tag) && !uncached;

    // The registered request decides the array update, so a late change on the core side is harmless.
    assign m_idx   = mem_addr[INDEX_BITS+1:2];
    assign m_tag   = mem_addr[31:INDEX_BITS+2];
    assign m_hit   = valid[m_idx] && (tag_mem[m_idx] == m_tag) && !mem_addr[UNCACHED_BIT];
    assign ack_now = (state == MEM) && bus.i_mem_ack;

    assign unused_addr_bits = ^bus.i_addr[1:0];

    always_comb begin
        // NOTE: merged gets a full default before the byte loop, so no path can infer a latch.
        merged = data_mem[m_idx];
        for (int b = 0; b < 4; b++) begin
            if (mem_wr[b]) merged[8*b +: 8] = mem_data_wr[8*b +: 8];
        end
    end

    // NOTE: tag/data arrays have no reset; the valid vector alone decides whether a line is usable.
    always_ff @(posedge i_clk) begin
        if (!i_rst && ack_now && !mem_addr[UNCACHED_BIT]) begin
            if (mem_rd) begin
                tag_mem[m_idx]  <= m_tag;
                data_mem[m_idx] <= bus.i_mem_data_rd;
            end else if (m_hit) begin
                data_mem[m_idx] <= merged;
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            valid       <= '0;
            buffer      <= '0;
            mem_addr    <= '0;
            mem_data_wr <= '0;
            mem_wr      <= '0;
            mem_rd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req || (rd_req && !hit)) begin
                        state       <= MEM;
                        mem_addr    <= {bus.i_addr[31:2], 2'b00};
                        mem_data_wr <= bus.i_data_wr;
                        mem_wr      <= bus.i_wr;
                        mem_rd      <= rd_req;
                    end
                end
                MEM: begin
                    if (bus.i_mem_ack) begin
                        state  <= DONE;
                        mem_wr <= '0;
                        mem_rd <= 1'b0;
                        if (mem_rd) begin
                            buffer <= bus.i_mem_data_rd;
                            if (!mem_addr[UNCACHED_BIT]) valid[m_idx] <= 1'b1;
                        end
                    end
                end
                // Holding here while the core is stalled elsewhere keeps a store from being replayed.
                DONE: begin
                    if (bus.i_ce) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_valid       = (state == DONE) || ((state == IDLE) && !wr_req && !(rd_req && !hit));
    assign bus.o_data_rd     = (state == DONE) ? buffer : data_mem[idx];
    assign bus.o_mem_addr    = mem_addr;
    assign bus.o_mem_data_wr = mem_data_wr;
    assign bus.o_mem_wr      = mem_wr;
    assign bus.o_mem_rd      = mem_rd;
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus randomized traffic against
// a line-level cache model and a word-addressed memory model.
module tb_dcache;
    localparam int IB    = 8;
    localparam int LINES = 1 << IB;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dcache_if bus ();

    dcache #(.INDEX_BITS(IB), .UNCACHED_BIT(31)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: which word each line holds, and the memory behind the cache.
    bit          m_valid [LINES];
    logic [31:0] m_addr  [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] mem_model [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // One core access; delay = MEM cycles until ack, hold = DONE cycles with i_ce low.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wr,
                          input int delay, input int hold,
                          output logic [31:0] rdata, output bit was_hit);
        logic [31:0] waddr;
        int          idx;
        bit          unc;
        bit          is_wr;
        bit          exp_hit;
        logic [31:0] memv;
        logic [31:0] newv;
        int          stalls;
        waddr   = {addr[31:2], 2'b00};
        idx     = (addr >> 2) % LINES;
        unc     = addr[31];
        is_wr   = (wr != 4'b0);
        exp_hit = !is_wr && !unc && m_valid[idx] && (m_addr[idx] == waddr);
        was_hit = 1'b0;
        rdata   = 32'h0;

        @(negedge clk);
        bus.i_addr = addr; bus.i_data_wr = wdata; bus.i_wr = wr; bus.i_rd = !is_wr;
        bus.i_ce = 1'b1; bus.i_mem_ack = 1'b0;
        #1;
        if (exp_hit) begin
            check("hit_valid", bus.o_valid, 1);
            check("hit_data", bus.o_data_rd, m_data[idx]);
            check("hit_no_strobe", {bus.o_mem_rd, bus.o_mem_wr}, 0);
            rdata   = bus.o_data_rd;
            was_hit = bus.o_valid;
            // A stray ack in IDLE must be ignored.
            bus.i_mem_ack = 1'($urandom_range(1)); bus.i_mem_data_rd = $urandom;
            return;
        end
        check("req_stall", bus.o_valid, 0);
        stalls = bus.o_valid ? 0 : 1;
        if (!mem_model.exists(waddr)) mem_model[waddr] = $urandom;
        memv = mem_model[waddr];

        for (int k = 1; k <= delay; k++) begin
            @(negedge clk);
            #1;
            check("mem_stall", bus.o_valid, 0);
            check("mem_rd", bus.o_mem_rd, !is_wr);
            check("mem_wr", bus.o_mem_wr, wr);
            check("mem_addr", bus.o_mem_addr, waddr);
            if (is_wr) check("mem_wdata", bus.o_mem_data_wr, wdata);
            if (!bus.o_valid) stalls++;
            if (k == delay) begin
                bus.i_mem_ack = 1'b1;
                bus.i_mem_data_rd = is_wr ? $urandom : memv;
            end
        end

        @(negedge clk);
        bus.i_mem_ack = 1'b0; bus.i_mem_data_rd = $urandom;
        #1;
        check("stall_cycles", stalls, delay + 1);

        if (is_wr) begin
            newv = merge(memv, wdata, wr);
            mem_model[waddr] = newv;
            if (!unc && m_valid[idx] && (m_addr[idx] == waddr)) m_data[idx] = merge(m_data[idx], wdata, wr);
        end else if (!unc) begin
            m_valid[idx] = 1'b1; m_addr[idx] = waddr; m_data[idx] = memv;
        end

        check("done_valid", bus.o_valid, 1);
        check("done_no_strobe", {bus.o_mem_rd, bus.o_mem_wr}, 0);
        if (!is_wr) check("done_data", bus.o_data_rd, memv);
        rdata = bus.o_data_rd;

        bus.i_ce = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            bus.i_mem_ack = 1'($urandom_range(1)); bus.i_mem_data_rd = $urandom;
            @(negedge clk);
            bus.i_mem_ack = 1'b0;
            #1;
            check("hold_valid", bus.o_valid, 1);
            check("hold_no_strobe", {bus.o_mem_rd, bus.o_mem_wr}, 0);
            if (!is_wr) check("hold_data", bus.o_data_rd, memv);
            if (h == hold - 1) bus.i_ce = 1'b1;
        end
    endtask

    task automatic idle_bus();
        bus.i_addr = '0; bus.i_data_wr = '0; bus.i_wr = '0; bus.i_rd = 1'b0;
        bus.i_ce = 1'b1; bus.i_mem_ack = 1'b0; bus.i_mem_data_rd = '0;
    endtask

    initial begin
        logic [31:0] rd;
        bit          h;
        logic [31:0] a;
        logic [3:0]  be;
        checks = 0; failures = 0;
        clear_model();
        idle_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", bus.o_valid, 1);
        check("rst_mem_rd", bus.o_mem_rd, 0);
        check("rst_mem_wr", bus.o_mem_wr, 0);
        check("rst_mem_addr", bus.o_mem_addr, 0);
        check("rst_mem_wdata", bus.o_mem_data_wr, 0);

        mem_model[32'h100] = 32'hDEADBEEF;
        access(32'h100, 0, 4'b0000, 2, 0, rd, h);
        check("plan_miss_data", rd, 32'hDEADBEEF);
        check("plan_miss_not_hit", h, 0);
        access(32'h100, 0, 4'b0000, 1, 0, rd, h);
        check("plan_rehit", h, 1);
        check("plan_rehit_data", rd, 32'hDEADBEEF);

        access(32'h100, 32'h0000AA00, 4'b0010, 1, 4, rd, h);
        access(32'h100, 0, 4'b0000, 1, 0, rd, h);
        check("plan_merge_hit", h, 1);
        check("plan_merge_data", rd, 32'hDEADAAEF);

        access(32'h200, 32'h11223344, 4'b1111, 2, 0, rd, h);
        access(32'h200, 0, 4'b0000, 1, 0, rd, h);
        check("plan_no_alloc", h, 0);
        check("plan_no_alloc_data", rd, 32'h11223344);

        access(32'h8000_0010, 0, 4'b0000, 1, 0, rd, h);
        check("plan_unc1", h, 0);
        access(32'h8000_0010, 0, 4'b0000, 3, 0, rd, h);
        check("plan_unc2", h, 0);

        access(32'h500, 0, 4'b0000, 1, 0, rd, h);
        check("plan_alias_miss", h, 0);
        access(32'h100, 0, 4'b0000, 1, 0, rd, h);
        check("plan_alias_evict", h, 0);

        // Reset while a read of 0x300 waits in MEM, then a late ack.
        @(negedge clk);
        bus.i_addr = 32'h300; bus.i_wr = '0; bus.i_rd = 1'b1; bus.i_ce = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid_mem_rd", bus.o_mem_rd, 1);
        rst = 1'b1; bus.i_rd = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid_rd_low", bus.o_mem_rd, 0);
        check("rstmid_wr_low", bus.o_mem_wr, 0);
        check("rstmid_valid", bus.o_valid, 1);
        rst = 1'b0; bus.i_mem_ack = 1'b1; bus.i_mem_data_rd = 32'h1234_5678;
        @(negedge clk);
        bus.i_mem_ack = 1'b0;
        clear_model();
        #1;
        check("rstmid_idle", bus.o_valid, 1);
        access(32'h300, 0, 4'b0000, 1, 0, rd, h);
        check("rstmid_remiss", h, 0);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) a = a | 32'h8000_0000;
            be = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            access(a, $urandom, be, $urandom_range(1, 3), $urandom_range(0, 2), rd, h);
        end

        @(negedge clk);
        idle_bus();
        repeat (3) @(negedge clk);
        #1;
        check("end_idle_valid", bus.o_valid, 1);
        check("end_no_strobe", {bus.o_mem_rd, bus.o_mem_wr}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
